// File: rtl/irq_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter: FSM encoding, PC-mux select
// code and default vector base.
package irq_arbiter_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_PEND    = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;

  localparam logic [2:0]  PCSEL_IRQ            = 3'd4;
  localparam logic [31:0] IRQ_VEC_BASE_DEFAULT = 32'h0000_0008;

  // Handler address for a source id; id is zero-extended, result wraps modulo 2^32.
  function automatic logic [31:0] irq_vec_addr(input logic [31:0] base,
                                               input logic [31:0] stride,
                                               input logic [3:0]  id);
    return base + (32'(id) * stride);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set and the
// index of the lowest set bit.
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req_i,
  output logic         valid_o,
  output logic [3:0]   id_o
);

  // Walk downwards so the lowest set index is the last one written.
  always_comb begin
    valid_o = 1'b0;
    id_o    = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        id_o    = 4'(i);
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Multi-source interrupt arbiter: pending capture, mask, fixed priority and a
// one-at-a-time IDLE/PEND/SERVICE loop. IRQ_EDGE_EN selects edge capture; otherwise level.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int          NSRC       = 8,
  parameter logic [31:0] VEC_BASE   = IRQ_VEC_BASE_DEFAULT,
  parameter int          VEC_STRIDE = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NSRC-1:0] src_irq,
  input  logic            mask_wr,
  input  logic [NSRC-1:0] mask_wdata,
  output logic [NSRC-1:0] mask_q,
  output logic [NSRC-1:0] pending_q,
  input  logic            supervisor,
  input  logic            insn_boundary,
  input  logic            eoi,
  output logic            irq,
  output logic [31:0]     xadr,
  output logic [3:0]      active_id,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  irq_state_e      state_q;
  logic [3:0]      active_id_q;
  logic [31:0]     xadr_q;
  logic            busy_q;
  logic [NSRC-1:0] pending_d;
  logic [NSRC-1:0] sel_oh;
  logic            win_valid;
  logic [3:0]      win_id;
  logic            cancel;
  logic            take;

  irq_prio_enc #(.N(NSRC)) u_enc (
    .req_i   (pending_q & mask_q),
    .valid_o (win_valid),
    .id_o    (win_id)
  );

  // One-hot of the latched source; avoids indexing NSRC-wide vectors with a 4-bit id.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NSRC; i++) begin
      sel_oh[i] = (active_id_q == 4'(i));
    end
  end

  assign irq    = (state_q == IRQ_PEND) && !supervisor;
  assign cancel = (state_q == IRQ_PEND) && ((mask_q & sel_oh) == '0);
  assign take   = irq && insn_boundary && !cancel;

`ifdef IRQ_EDGE_EN
  logic [NSRC-1:0] prev_q;

  // A fresh edge on the take cycle re-sets the bit the take is clearing.
  always_comb begin
    pending_d = (pending_q & ~(take ? sel_oh : '0)) | (src_irq & ~prev_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_q <= '0;
    else          prev_q <= src_irq;
  end
`else
  always_comb begin
    pending_d = src_irq;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q    <= '0;
      pending_q <= '0;
    end else begin
      if (mask_wr) mask_q <= mask_wdata;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IRQ_IDLE;
      active_id_q <= 4'd0;
      xadr_q      <= VEC_BASE;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          if (win_valid && !supervisor) begin
            state_q     <= IRQ_PEND;
            active_id_q <= win_id;
            xadr_q      <= irq_vec_addr(VEC_BASE, 32'(VEC_STRIDE), win_id);
          end
        end
        IRQ_PEND: begin
          if (cancel) begin
            state_q <= IRQ_IDLE;
          end else if (take) begin
            state_q <= IRQ_SERVICE;
            busy_q  <= 1'b1;
          end
        end
        IRQ_SERVICE: begin
          if (eoi) begin
            state_q <= IRQ_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IRQ_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign xadr      = xadr_q;
  assign active_id = active_id_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Multi-source interrupt arbiter for the RISC core.
- Latches requests from NSRC peripheral lines, applies a software mask and fixed priority, and drives the single `irq` input of the control decoder.
- Presents the selected handler address (`xadr`) to the PC mux for pcsel=4.
- Keeps the core in one-interrupt-at-a-time service until software signals end-of-interrupt.

Parameters:
- NSRC, 8, number of interrupt sources (1..16).
- VEC_BASE, 32'h0000_0008, handler address for source 0.
- VEC_STRIDE, 4, byte spacing between per-source vectors.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- src_irq  in  NSRC  raw interrupt lines from peripherals, synchronous to clk.
- mask_wr  in  1  one-cycle strobe: load mask from mask_wdata.
- mask_wdata  in  NSRC  new enable mask; 1 = enabled.
- mask_q  out  NSRC  current mask.
- pending_q  out  NSRC  current pending vector.
- supervisor  in  1  core in supervisor mode (PC[31]); blocks interrupt entry.
- insn_boundary  in  1  core accepts a new instruction this cycle.
- eoi  in  1  one-cycle end-of-interrupt strobe from software.
- irq  out  1  interrupt request to the control decoder.
- xadr  out  32  handler address.
- active_id  out  4  source currently latched or being serviced.
- busy  out  1  state is SERVICE.

Behaviour:
- Reset (async assert, sync-safe release):
  - mask, pending, active_id = 0; state = IDLE.
  - irq = 0, busy = 0, xadr = VEC_BASE.
- Pending capture:
  - pending[i] sets on a rising edge of src_irq[i]; prev-sample register, one cycle capture latency.
  - pending[i] clears only when source i is taken.
  - A new edge in the same cycle as the take wins: the bit stays set.
- Winner: lowest index i with pending[i] & mask[i]. mask_wr takes effect the next cycle.
- State machine, 2-bit: IDLE, PEND, SERVICE.
  - IDLE -> PEND: any enabled pending bit and supervisor=0. Latch winner into active_id.
  - PEND -> IDLE (cancel): mask[active_id] becomes 0.
  - PEND -> SERVICE (take): insn_boundary & irq. Clear pending[active_id].
  - PEND, no cancel and no take: hold. A later higher-priority arrival does not replace the latched winner.
  - SERVICE -> IDLE: eoi=1. Next arbitration happens the following cycle, so there is at least one cycle of IDLE.
  - eoi in IDLE or PEND: ignored.
- Outputs:
  - irq = (state==PEND) & ~supervisor. This is the only combinational path from an input.
  - xadr = VEC_BASE + active_id*VEC_STRIDE, registered on the IDLE->PEND transition and held through SERVICE.
  - busy = (state==SERVICE).
- Latency: src_irq edge at cycle N -> pending at N+1 -> PEND with irq=1 at N+2, provided enabled, IDLE and not supervisor.
- Reset mid-operation: any state returns to IDLE immediately; pending events are lost.
- Width: active_id is zero-extended to 32 bits before the multiply; the sum wraps modulo 2^32.

Optional Feature:
- IRQ_EDGE_EN defined (default build): edge-capture pending register as described above.
- IRQ_EDGE_EN undefined: level-sensitive mode.
  - pending = src_irq directly; the take does not clear it, and the peripheral must drop the line before eoi.
  - An asserted line re-enters PEND after eoi.

Decomposition:
- Add to risc_constants.vh:
  - IRQ_IDLE/IRQ_PEND/IRQ_SERVICE state encodings.
  - PCSEL_IRQ = 3'd4.
  - Default VEC_BASE.
- One sub-module: irq_prio_enc, a parameterised lowest-index-first priority encoder (pending & mask -> valid, id).

Test Plan:
- Reset sequencing:
  - mask=8'hFF, src_irq[3] rising at cycle 10 -> irq=1 at cycle 12, active_id=3, xadr=32'h14.
  - insn_boundary=1 -> busy=1, pending_q=0, irq=0.
  - eoi -> IDLE.
- Priority:
  - src 5 and src 1 edge on the same cycle -> active_id=1, xadr=32'h0C.
  - After take and eoi -> active_id=5, xadr=32'h1C.
- Supervisor block and cancel:
  - supervisor=1 with enabled pending -> irq stays 0 indefinitely; drop supervisor -> irq after 1 cycle.
  - In PEND, write mask=0 -> state IDLE, irq=0, pending kept.
- Edge coincident with take:
  - src 2 re-edges on the take cycle -> pending_q[2]=1 after take.
  - After eoi -> re-enters PEND with id 2.
- Async reset:
  - Assert reset_n=0 mid-SERVICE between clock edges -> busy=0, irq=0, pending=0, mask=0, xadr=32'h8 without waiting for clk.
- Build with IRQ_EDGE_EN undefined:
  - Hold src 0 high through eoi -> second PEND one cycle after IDLE.
  - Drop src 0 before eoi -> no re-entry.
